// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: issues PC-ordered requests to the instruction memory, pairs in-order
// responses with their PCs in a small FIFO, and discards in-flight responses after a redirect.
module instr_fetch_ctrl #(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic                 mem_reset_n,
  output logic                 mem_next_instr,
  input  logic [BUS_WIDTH-1:0] mem_instr,
  input  logic                 mem_instr_valid,
  output logic                 out_valid,
  output logic [BUS_WIDTH-1:0] out_instr,
  output logic [31:0]          out_pc,
  input  logic                 out_ready,
  input  logic                 flush,
  input  logic [31:0]          flush_pc,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW:0] DepthSum = DEPTH[CntW:0];

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e               state_q, state_d;
  logic [31:0]          fetch_pc_q, fetch_pc_d;
  logic [31:0]          resp_pc_q, resp_pc_d;
  logic [CntW-1:0]      outstanding_q, outstanding_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [CntW-1:0]      drop_cnt_q, drop_cnt_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic                 err_q, err_d;
  logic                 mem_reset_n_q;
  logic [BUS_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [31:0]          pc_mem_q    [DEPTH];

  logic                 req;
  logic                 resp_ok;
  logic                 unsolicited;
  logic                 push;
  logic                 pop;
  logic [CntW:0]        credit_used;

  always_comb begin
    // Credits cover both queued entries and in-flight requests, so a push can never overflow.
    credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
    req         = (state_q == StFetch) && !flush && (credit_used < DepthSum);
    resp_ok     = mem_instr_valid && (outstanding_q != '0);
    unsolicited = mem_instr_valid && (outstanding_q == '0);
    pop         = (count_q != '0) && out_ready && !flush;
    push        = resp_ok && (drop_cnt_q == '0) && !flush;

    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    drop_cnt_d    = drop_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    err_d         = err_q | unsolicited;

    if (flush) begin
      // A response landing in the flush cycle is consumed here and never counted as stale.
      fetch_pc_d    = flush_pc;
      resp_pc_d     = flush_pc;
      outstanding_d = outstanding_q - CntW'(resp_ok);
      drop_cnt_d    = outstanding_d;
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      if (drop_cnt_d != '0) begin
        state_d = StDrain;
      end else begin
        state_d = en ? StFetch : StIdle;
      end
    end else begin
      if (req) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outstanding_d = outstanding_q + CntW'(req) - CntW'(resp_ok);
      if (resp_ok && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CntW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);

      case (state_q)
        StIdle:  if (en) state_d = StFetch;
        StFetch: if (!en) state_d = StIdle;
        StDrain: if (drop_cnt_d == '0) state_d = en ? StFetch : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      count_q       <= '0;
      drop_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      err_q         <= 1'b0;
      mem_reset_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      err_q         <= err_d;
      mem_reset_n_q <= 1'b1;
    end
  end

  // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= mem_instr;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  always_comb begin
    out_valid      = (count_q != '0);
    out_instr      = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    out_pc         = out_valid ? pc_mem_q[rd_ptr_q] : '0;
    busy           = (count_q != '0) || (outstanding_q != '0);
    err            = err_q;
    mem_next_instr = req;
    mem_reset_n    = mem_reset_n_q;
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: in-order memory model with programmable latency and a
// second instance checking PC wrap from a high reset address.
module tb_instr_fetch_ctrl;

  localparam int unsigned Depth = 4;
  localparam logic [31:0] Key   = 32'h5A5A_A5A5;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        out_ready = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        mem_instr_valid = 1'b0;
  logic [31:0] mem_instr = '0;
  logic        mem_reset_n, mem_next_instr, out_valid, busy, err;
  logic [31:0] out_instr, out_pc;

  logic        en_b = 1'b1;
  logic        out_ready_b = 1'b1;
  logic        flush_b = 1'b0;
  logic [31:0] flush_pc_b = '0;
  logic        mem_instr_valid_b = 1'b0;
  logic [31:0] mem_instr_b = '0;
  logic        mem_reset_n_b, mem_next_instr_b, out_valid_b, busy_b, err_b;
  logic [31:0] out_instr_b, out_pc_b;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  rsp_t        q[$];
  logic [31:0] mpc = 32'h0;
  logic [31:0] exp_pc = 32'h0;
  logic        inject = 1'b0;
  int          n_req = 0;
  int          n_idle = 0;
  logic        pend_b = 1'b0;
  logic [31:0] mpc_b = 32'hFFFF_FFF8;
  logic [31:0] data_b = '0;
  logic [31:0] pcs_b [3];
  int          nb = 0;

  instr_fetch_ctrl #(.BUS_WIDTH(32), .DEPTH(Depth), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .en(en), .mem_reset_n(mem_reset_n),
    .mem_next_instr(mem_next_instr), .mem_instr(mem_instr), .mem_instr_valid(mem_instr_valid),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
    .flush(flush), .flush_pc(flush_pc), .busy(busy), .err(err)
  );

  instr_fetch_ctrl #(.BUS_WIDTH(32), .DEPTH(Depth), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .mem_reset_n(mem_reset_n_b),
    .mem_next_instr(mem_next_instr_b), .mem_instr(mem_instr_b),
    .mem_instr_valid(mem_instr_valid_b), .out_valid(out_valid_b), .out_instr(out_instr_b),
    .out_pc(out_pc_b), .out_ready(out_ready_b), .flush(flush_b), .flush_pc(flush_pc_b),
    .busy(busy_b), .err(err_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory responses, score the FIFO head, then record requests.
  task automatic tick();
    logic req_a, req_b, fl, inflight_ok;
    mem_instr_valid = 1'b0;
    mem_instr       = '0;
    if (q.size() != 0 && q[0].due <= cyc) begin
      mem_instr_valid = 1'b1;
      mem_instr       = q[0].data;
      void'(q.pop_front());
    end else if (inject) begin
      mem_instr_valid = 1'b1;
      mem_instr       = 32'hBAD0_0BAD;
    end
    mem_instr_valid_b = pend_b;
    mem_instr_b       = pend_b ? data_b : '0;
    #1;
    req_a = mem_next_instr;
    req_b = mem_next_instr_b;
    fl    = flush;
    if (out_valid) begin
      check("head_pc", {32'h0, out_pc}, {32'h0, exp_pc});
      check("head_instr", {32'h0, out_instr}, {32'h0, exp_pc ^ Key});
      if (out_ready && !fl) exp_pc = exp_pc + 32'd4;
    end
    if (out_valid_b && nb < 3) begin
      pcs_b[nb] = out_pc_b;
      nb++;
    end
    if (req_a) n_req++;
    else n_idle++;
    @(posedge clk);
    cyc++;
    if (req_a) begin
      q.push_back('{mpc ^ Key, cyc + lat - 1});
      mpc = mpc + 32'd4;
    end
    if (fl) begin
      mpc    = flush_pc;
      exp_pc = flush_pc;
    end
    inflight_ok = (q.size() <= int'(Depth));
    check("inflight_le_depth", {63'h0, inflight_ok}, 64'd1);
    pend_b = req_b;
    if (req_b) begin
      data_b = mpc_b ^ Key;
      mpc_b  = mpc_b + 32'd4;
    end
    #1;
  endtask

  initial begin
    // Reset values while reset is held.
    tick();
    tick();
    check("rst_mem_reset_n", {63'h0, mem_reset_n}, 64'd0);
    check("rst_next_instr", {63'h0, mem_next_instr}, 64'd0);
    check("rst_out_valid", {63'h0, out_valid}, 64'd0);
    check("rst_out_instr", {32'h0, out_instr}, 64'd0);
    check("rst_out_pc", {32'h0, out_pc}, 64'd0);
    check("rst_busy", {63'h0, busy}, 64'd0);
    check("rst_err", {63'h0, err}, 64'd0);
    check("rst_b_out_pc", {32'h0, out_pc_b}, 64'd0);

    // Release: first request and mem_reset_n follow the first edge.
    reset = 1'b0;
    en    = 1'b1;
    #1;
    check("rel_mem_reset_n", {63'h0, mem_reset_n}, 64'd0);
    check("rel_next_instr", {63'h0, mem_next_instr}, 64'd0);
    tick();
    check("e1_mem_reset_n", {63'h0, mem_reset_n}, 64'd1);
    check("e1_next_instr", {63'h0, mem_next_instr}, 64'd1);
    tick();
    check("e2_out_valid", {63'h0, out_valid}, 64'd0);
    tick();
    check("e3_out_valid", {63'h0, out_valid}, 64'd1);
    check("e3_out_pc", {32'h0, out_pc}, 64'd0);
    check("e3_out_instr", {32'h0, out_instr}, {32'h0, Key});
    for (int i = 0; i < 8; i++) begin
      tick();
      check("b2b_valid", {63'h0, out_valid}, 64'd1);
      check("b2b_req", {63'h0, mem_next_instr}, 64'd1);
    end
    check("l1_err", {63'h0, err}, 64'd0);
    check("wrap_nb", nb, 64'd3);
    check("wrap_pc0", {32'h0, pcs_b[0]}, {32'h0, 32'hFFFF_FFF8});
    check("wrap_pc1", {32'h0, pcs_b[1]}, {32'h0, 32'hFFFF_FFFC});
    check("wrap_pc2", {32'h0, pcs_b[2]}, {32'h0, 32'h0000_0000});

    // Long latency: credits must stall requests.
    lat    = 5;
    n_req  = 0;
    n_idle = 0;
    for (int i = 0; i < 30; i++) tick();
    check("l5_stalled", {63'h0, n_idle > 0}, 64'd1);
    check("l5_requested", {63'h0, n_req > 0}, 64'd1);

    // Backpressure: FIFO fills, requests stop, head holds.
    lat = 1;
    for (int i = 0; i < 8; i++) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("bp_next_instr", {63'h0, mem_next_instr}, 64'd0);
    check("bp_out_valid", {63'h0, out_valid}, 64'd1);
    check("bp_busy", {63'h0, busy}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Flush with 3 in flight and one response landing in the flush cycle.
    en = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    check("pre_flush_idle", {63'h0, busy}, 64'd0);
    lat = 3;
    en  = 1'b1;
    tick();
    check("fl_req_a", {63'h0, mem_next_instr}, 64'd1);
    tick();
    tick();
    tick();
    check("fl_busy_before", {63'h0, busy}, 64'd1);
    flush    = 1'b1;
    flush_pc = 32'h0000_0100;
    tick();
    flush = 1'b0;
    check("fl_out_valid", {63'h0, out_valid}, 64'd0);
    check("fl_drain_req", {63'h0, mem_next_instr}, 64'd0);
    check("fl_busy", {63'h0, busy}, 64'd1);
    tick();
    check("fl_drain_req2", {63'h0, mem_next_instr}, 64'd0);
    tick();
    check("fl_resume_req", {63'h0, mem_next_instr}, 64'd1);
    check("fl_all_dropped", {63'h0, busy}, 64'd0);
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    check("fl_first_valid", {63'h0, out_valid}, 64'd1);
    check("fl_pc_100", {32'h0, out_pc}, 64'h100);
    tick();
    check("fl_pc_104", {32'h0, out_pc}, 64'h104);
    check("fl_err", {63'h0, err}, 64'd0);

    // Unsolicited response.
    en = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    check("pre_unsol_idle", {63'h0, busy}, 64'd0);
    check("pre_unsol_err", {63'h0, err}, 64'd0);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    check("unsol_err", {63'h0, err}, 64'd1);
    check("unsol_out_valid", {63'h0, out_valid}, 64'd0);
    check("unsol_busy", {63'h0, busy}, 64'd0);
    tick();
    tick();
    check("unsol_err_sticky", {63'h0, err}, 64'd1);

    // Asynchronous reset mid-stream; later responses become unsolicited.
    en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("mid_busy", {63'h0, busy}, 64'd1);
    reset = 1'b1;
    #2;
    check("arst_mem_reset_n", {63'h0, mem_reset_n}, 64'd0);
    check("arst_next_instr", {63'h0, mem_next_instr}, 64'd0);
    check("arst_out_valid", {63'h0, out_valid}, 64'd0);
    check("arst_out_instr", {32'h0, out_instr}, 64'd0);
    check("arst_out_pc", {32'h0, out_pc}, 64'd0);
    check("arst_busy", {63'h0, busy}, 64'd0);
    check("arst_err", {63'h0, err}, 64'd0);
    reset  = 1'b0;
    en     = 1'b0;
    exp_pc = 32'h0;
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_err", {63'h0, err}, 64'd1);
    check("post_rst_out_valid", {63'h0, out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
